// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage; latches the EXE bundle, aligns and extends load data, hands off to WB.
// Ports: clk/resetn (async active-low), flush from WB; exe_to_mem_valid/exe_to_mem_zip/mem_allowin from EXE;
//        mem_to_wb_valid/mem_to_wb_zip/wb_allowin to WB; data_sram_rdata load word; mem_rf_zip forward to ID;
//        mem_ex exception/ertn in flight, to EXE.
module mem_stage #(
  parameter int EXE2MEM_LEN = 204,
  parameter int MEM2WB_LEN  = 199
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  output logic                   mem_allowin,
  input  logic                   exe_to_mem_valid,
  input  logic [EXE2MEM_LEN-1:0] exe_to_mem_zip,
  input  logic                   wb_allowin,
  output logic                   mem_to_wb_valid,
  output logic [MEM2WB_LEN-1:0]  mem_to_wb_zip,
  input  logic [31:0]            data_sram_rdata,
  output logic [38:0]            mem_rf_zip,
  output logic                   mem_ex
);
  logic                   valid_q, valid_d;
  logic                   first_q, first_d;
  logic [31:0]            hold_q, hold_d;
  logic [EXE2MEM_LEN-1:0] zip_q, zip_d;
  logic                   accept;
  logic                   res_from_mem, rf_we, csr_read, ex_valid, is_ertn, zext;
  logic [4:0]             rf_waddr;
  logic [31:0]            result, vaddr, rdata, shifted, load_data, final_result;
  logic [1:0]             ld_type;
  logic [15:0]            half;
  logic [7:0]             byte_d;
  logic                   unused_op2;
  assign res_from_mem = zip_q[203];
  assign rf_we        = zip_q[202];
  assign rf_waddr     = zip_q[201:197];
  assign result       = zip_q[196:165];
  assign zext         = zip_q[164];
  assign unused_op2   = zip_q[163];
  assign ld_type      = zip_q[162:161];
  assign csr_read     = zip_q[128];
  assign vaddr        = zip_q[48:17];
  assign ex_valid     = zip_q[16];
  assign is_ertn      = zip_q[0];
  assign mem_allowin     = ~valid_q | wb_allowin;
  assign mem_to_wb_valid = valid_q;
  assign accept          = exe_to_mem_valid & mem_allowin;
  always_comb begin
    valid_d = flush ? 1'b0 : (mem_allowin ? exe_to_mem_valid : valid_q);
    first_d = accept;
    zip_d   = accept ? exe_to_mem_zip : zip_q;
    hold_d  = first_q ? data_sram_rdata : hold_q;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      valid_q <= 1'b0;
      first_q <= 1'b0;
      hold_q  <= 32'd0;
      zip_q   <= '0;
    end else begin
      valid_q <= valid_d;
      first_q <= first_d;
      hold_q  <= hold_d;
      zip_q   <= zip_d;
    end
  // The SRAM word is only present on the first MEM cycle; stalls replay it from hold_q.
  always_comb begin
    rdata        = first_q ? data_sram_rdata : hold_q;
    shifted      = rdata >> {vaddr[1:0], 3'b000};
    byte_d       = shifted[7:0];
    half         = vaddr[1] ? rdata[31:16] : rdata[15:0];
    load_data    = ld_type == 2'd0 ? {{24{~zext & byte_d[7]}}, byte_d} :
                   ld_type == 2'd1 ? {{16{~zext & half[15]}}, half} : rdata;
    final_result = (res_from_mem & ~ex_valid) ? load_data : result;
  end
  assign mem_to_wb_zip = {rf_we, rf_waddr, final_result, zip_q[160:0]};
  assign mem_rf_zip    = {valid_q & csr_read, valid_q & rf_we, rf_waddr, final_result};
  assign mem_ex        = valid_q & (ex_valid | is_ertn);
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage with directed load vectors, stalls, flush and async reset.
module tb_mem_stage;
  logic         clk = 1'b0;
  logic         resetn, flush, exe_to_mem_valid, wb_allowin;
  logic [203:0] exe_to_mem_zip;
  logic [31:0]  data_sram_rdata;
  logic         mem_allowin, mem_to_wb_valid, mem_ex;
  logic [198:0] mem_to_wb_zip;
  logic [38:0]  mem_rf_zip;
  logic [198:0] sb[$];
  logic [198:0] e;
  int           checks = 0;
  int           failures = 0;
  int           n = 0;
  mem_stage dut (
    .clk(clk), .resetn(resetn), .flush(flush), .mem_allowin(mem_allowin),
    .exe_to_mem_valid(exe_to_mem_valid), .exe_to_mem_zip(exe_to_mem_zip),
    .wb_allowin(wb_allowin), .mem_to_wb_valid(mem_to_wb_valid), .mem_to_wb_zip(mem_to_wb_zip),
    .data_sram_rdata(data_sram_rdata), .mem_rf_zip(mem_rf_zip), .mem_ex(mem_ex)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [198:0] act, input logic [198:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  task automatic issue(input logic rfm, input logic exv, input logic [3:0] op, input logic [31:0] va,
                       input logic [31:0] res, input logic [31:0] rd, input logic [31:0] expw);
    logic [203:0] z;
    int k = 0;
    while (!mem_allowin && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (!mem_allowin) chk("allowin_timeout", 199'(mem_allowin), 199'd1);
    z = {rfm, 1'b1, 5'(n + 1), res, op, 32'h1c000000 + 32'(n * 4), n[0], n[1], 14'(n + 256),
         32'hF0F00000 | 32'(n), 32'hA5A50000 + 32'(n), va, exv, exv ? 6'h09 : 6'h00, 9'(n), 1'b0};
    exe_to_mem_zip = z;
    exe_to_mem_valid = 1'b1;
    sb.push_back({z[202], z[201:197], expw, z[160:0]});
    @(posedge clk); #1;
    exe_to_mem_valid = 1'b0;
    data_sram_rdata = rd;
    n++;
  endtask
  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("drain_empty", 199'(sb.size()), 199'd0);
  endtask
  always @(negedge clk)
    if (resetn && mem_to_wb_valid) begin
      if (sb.size() == 0) chk("unexpected_output", 199'(mem_to_wb_valid), 199'd0);
      else begin
        e = sb[0];
        chk("wb_zip", mem_to_wb_zip, e);
        chk("rf_zip", 199'(mem_rf_zip), 199'({e[128], e[198], e[197:161]}));
        chk("mem_ex", 199'(mem_ex), 199'(e[16] | e[0]));
        if (wb_allowin || flush) void'(sb.pop_front());
      end
    end
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    resetn = 1'b1; flush = 1'b0; exe_to_mem_valid = 1'b0; exe_to_mem_zip = '0;
    wb_allowin = 1'b1; data_sram_rdata = '0;
    #1 resetn = 1'b0;
    #2;
    chk("rst_valid", 199'(mem_to_wb_valid), 199'd0);
    chk("rst_allowin", 199'(mem_allowin), 199'd1);
    chk("rst_ex", 199'(mem_ex), 199'd0);
    chk("rst_rfzip_hi", 199'(mem_rf_zip[38:37]), 199'd0);
    #19 resetn = 1'b1;
    @(posedge clk); #1;
    issue(1, 0, 4'd0, 32'h00000003, 32'h0, 32'h80112233, 32'hFFFFFF80);
    issue(1, 0, 4'd9, 32'h00000002, 32'h0, 32'h80011234, 32'h00008001);
    issue(1, 0, 4'd8, 32'h00000001, 32'h0, 32'h80112233, 32'h00000022);
    issue(1, 0, 4'd0, 32'h00000000, 32'h0, 32'h000000F0, 32'hFFFFFFF0);
    issue(1, 0, 4'd1, 32'h00000000, 32'h0, 32'h12348001, 32'hFFFF8001);
    issue(1, 0, 4'd1, 32'h00000002, 32'h0, 32'h7FFF0000, 32'h00007FFF);
    issue(1, 0, 4'd2, 32'h00000000, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D);
    issue(0, 0, 4'd2, 32'h00000000, 32'h00000055, 32'hFFFFFFFF, 32'h00000055);
    drain();
    wb_allowin = 1'b0;
    issue(1, 0, 4'd2, 32'h00000004, 32'h0, 32'h12345678, 32'h12345678);
    @(posedge clk); #1;
    data_sram_rdata = 32'hDEADBEEF;
    chk("stall_valid", 199'(mem_to_wb_valid), 199'd1);
    chk("stall_allowin", 199'(mem_allowin), 199'd0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("stall_valid", 199'(mem_to_wb_valid), 199'd1);
    end
    wb_allowin = 1'b1;
    @(posedge clk); #1;
    chk("stall_release", 199'(mem_to_wb_valid), 199'd0);
    drain();
    wb_allowin = 1'b0;
    issue(1, 1, 4'd2, 32'h00000005, 32'hBAD00005, 32'h11111111, 32'hBAD00005);
    chk("ex_out", 199'(mem_ex), 199'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_valid", 199'(mem_to_wb_valid), 199'd0);
    chk("flush_ex", 199'(mem_ex), 199'd0);
    chk("flush_allowin", 199'(mem_allowin), 199'd1);
    wb_allowin = 1'b1;
    drain();
    exe_to_mem_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    exe_to_mem_valid = 1'b0;
    flush = 1'b0;
    chk("flush_beats_load", 199'(mem_to_wb_valid), 199'd0);
    wb_allowin = 1'b0;
    issue(1, 0, 4'd2, 32'h00000000, 32'h0, 32'h0BADF00D, 32'h0BADF00D);
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    chk("arst_valid", 199'(mem_to_wb_valid), 199'd0);
    chk("arst_ex", 199'(mem_ex), 199'd0);
    chk("arst_allowin", 199'(mem_allowin), 199'd1);
    chk("arst_rfzip_hi", 199'(mem_rf_zip[38:37]), 199'd0);
    sb.delete();
    #3 resetn = 1'b1;
    wb_allowin = 1'b1;
    issue(1, 0, 4'd10, 32'h00000000, 32'h0, 32'h87654321, 32'h87654321);
    chk("post_rst_accept", 199'(mem_to_wb_valid), 199'd1);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter EXE2MEM_LEN, 204, width of the EXE-to-MEM bundle.
REQ-002 SHALL have parameter MEM2WB_LEN, 199, width of the MEM-to-WB bundle.
REQ-003 SHALL have port clk  in  1  sole clock; all state rises on posedge.
REQ-004 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  in  1  global flush from WB (exception or ertn).
REQ-006 SHALL have port mem_allowin  out  1  MEM stage can accept from EXE.
REQ-007 SHALL have port exe_to_mem_valid  in  1  EXE bundle valid.
REQ-008 SHALL have port exe_to_mem_zip  in  EXE2MEM_LEN  MSB-first fields: res_from_mem1, rf_we1, rf_waddr5, result32, mem_op4, pc32, csr_read1, csr_we1, csr_num14, csr_wmask32, csr_wvalue32, vaddr32, ex_valid1, ecode6, esubcode9, is_ertn1.
REQ-009 SHALL have port wb_allowin  in  1  WB can accept.
REQ-010 SHALL have port mem_to_wb_valid  out  1  MEM bundle valid.
REQ-011 SHALL have port mem_to_wb_zip  out  MEM2WB_LEN  MSB-first fields: rf_we1, rf_waddr5, rf_wdata32, pc32, csr_read1, csr_we1, csr_num14, csr_wmask32, csr_wvalue32, vaddr32, ex_valid1, ecode6, esubcode9, is_ertn1.
REQ-012 SHALL have port data_sram_rdata  in  32  SRAM read word, valid the cycle after EXE issued the request.
REQ-013 SHALL have port mem_rf_zip  out  39  {valid&csr_read, valid&rf_we, rf_waddr, final_result} forwarded to ID.
REQ-014 SHALL have port mem_ex  out  1  mem_valid & (ex_valid | is_ertn), to EXE.

Function
REQ-015 mem_valid SHALL load exe_to_mem_valid when mem_allowin=1, hold otherwise, and clear on flush (flush beats any load).
REQ-016 mem_allowin SHALL equal ~mem_valid | (mem_ready_go & wb_allowin); mem_ready_go SHALL be 1 (single-cycle stage).
REQ-017 mem_to_wb_valid SHALL equal mem_valid & mem_ready_go.
REQ-018 Bundle registers SHALL capture exe_to_mem_zip only on exe_to_mem_valid & mem_allowin.
REQ-019 A first-cycle flag SHALL be set on each accepted bundle and cleared the next cycle.
REQ-020 On the first cycle, rdata SHALL come straight from data_sram_rdata and be latched into a 32-bit hold register; on later stalled cycles, it SHALL come from the hold register.
REQ-021 Byte select SHALL be vaddr[1:0]; halfword select SHALL be vaddr[1].
REQ-022 Load type SHALL come from mem_op[1:0] (0 byte, 1 half, 2 word); mem_op[3]=1 SHALL mean zero-extend, else sign-extend.
REQ-023 final_result SHALL be the extended load data when res_from_mem=1 and ex_valid=0, else result.
REQ-024 When ex_valid=1, SRAM data SHALL be ignored and final_result SHALL equal result.
REQ-025 rf_we, csr and exception fields SHALL pass through unmodified; rf_wdata SHALL equal final_result.
REQ-026 With mem_valid=0, mem_rf_zip bits 38:37 and mem_ex SHALL be 0.

Reset
REQ-027 Async resetn=0 SHALL immediately clear mem_valid, the first-cycle flag and the hold register, so mem_to_wb_valid=0, mem_ex=0 and mem_allowin=1.
REQ-028 Reset during a stalled load SHALL discard the bundle; after release, the stage SHALL accept a new bundle on the first edge.

Verification
REQ-029 ld.b (mem_op 0), vaddr 0x...3, rdata 0x80112233, wb_allowin=1 -> rf_wdata 0xFFFFFF80 next stage, one cycle.
REQ-030 ld.hu (mem_op 9), vaddr 0x...2, rdata 0x8001_1234 -> rf_wdata 0x00008001.
REQ-031 ld.w accepted, wb_allowin=0 for 3 cycles, rdata changes to 0xDEADBEEF after first cycle -> output holds original word 0x12345678 throughout, valid stays 1.
REQ-032 Bundle with ex_valid=1, ecode ALE -> mem_ex=1, rf_wdata=result, rdata ignored; flush next cycle -> mem_valid=0.
REQ-033 flush asserted together with exe_to_mem_valid=1 -> mem_valid=0 next cycle.
REQ-034 resetn pulsed low mid-stall -> outputs 0 asynchronously, mem_allowin=1.
